// File: rtl/sobel_window_fetch.sv
`default_nettype none
// ============================================================================
// Module  : sobel_window_fetch
// Brief   : Fetches 3x3 word neighbourhoods and emits zero-padded 3x6-pixel
//           Sobel windows over a valid/ready handshake.
// Revision: 1.0 - initial release
// ============================================================================
module sobel_window_fetch #(
  parameter int IMG_W_WORDS = 88,
  parameter int IMG_H       = 288,
  parameter int SRC_BASE    = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  output logic [15:0]  addr,
  output logic         en,
  output logic         we,
  input  logic [31:0]  dataR,
  output logic         win_valid,
  input  logic         win_ready,
  output logic [143:0] win,
  output logic [8:0]   win_row,
  output logic [6:0]   win_col,
  output logic         win_first,
  output logic         win_last,
  output logic         finish
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRIME = 3'd1,
    S_FETCH = 3'd2,
    S_EMIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [15:0] c_W        = 16'(IMG_W_WORDS);
  localparam logic [15:0] c_BASE     = 16'(SRC_BASE);
  localparam logic [8:0]  c_LAST_ROW = 9'(IMG_H - 1);
  localparam logic [6:0]  c_LAST_COL = 7'(IMG_W_WORDS - 1);

  state_t                  r_state;
  logic [1:0]              r_cyc;
  logic [8:0]              r_row;
  logic [6:0]              r_col;
  logic [15:0]             r_row_base;
  logic                    r_en_d;
  logic                    r_valid;
  logic                    r_finish;
  // [row k][column m]: m = 0,1,2 holds word columns c-1, c, c+1
  logic [2:0][2:0][31:0]   r_win;

  logic                    w_load_phase;
  logic                    w_capture;
  logic [1:0]              w_cap_row;
  logic [31:0]             w_cap_word;
  logic [6:0]              w_fcol;
  logic                    w_row_ok;
  logic                    w_col_ok;
  logic [15:0]             w_addr;

  // Read issue: cycle 0/1/2 address rows r-1/r/r+1; PRIME targets column c, FETCH c+1.
  always_comb begin
    w_load_phase = (r_state == S_PRIME) || (r_state == S_FETCH);
    w_fcol       = (r_state == S_FETCH) ? r_col + 7'd1 : r_col;
    w_col_ok     = (w_fcol <= c_LAST_COL);
    w_row_ok     = 1'b0;
    w_addr       = r_row_base;
    unique case (r_cyc)
      2'd0: begin
        w_row_ok = (r_row != 9'd0);
        w_addr   = r_row_base - c_W + {9'd0, w_fcol};
      end
      2'd1: begin
        w_row_ok = 1'b1;
        w_addr   = r_row_base + {9'd0, w_fcol};
      end
      2'd2: begin
        w_row_ok = (r_row != c_LAST_ROW);
        w_addr   = r_row_base + c_W + {9'd0, w_fcol};
      end
      default: begin
        w_row_ok = 1'b0;
        w_addr   = r_row_base;
      end
    endcase
    en         = w_load_phase && (r_cyc != 2'd3) && w_row_ok && w_col_ok;
    addr       = en ? w_addr : 16'd0;
    we         = 1'b0;
    w_capture  = w_load_phase && (r_cyc != 2'd0);
    w_cap_row  = r_cyc - 2'd1;
    w_cap_word = r_en_d ? dataR : 32'd0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cyc      <= 2'd0;
      r_row      <= 9'd0;
      r_col      <= 7'd0;
      r_row_base <= c_BASE;
      r_en_d     <= 1'b0;
      r_valid    <= 1'b0;
      r_finish   <= 1'b0;
      r_win      <= '0;
    end else begin
      r_en_d <= en;
      if (w_capture) begin
        if (r_state == S_PRIME) r_win[w_cap_row][1] <= w_cap_word;
        else                    r_win[w_cap_row][2] <= w_cap_word;
      end
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state    <= S_PRIME;
            r_cyc      <= 2'd0;
            r_row      <= 9'd0;
            r_col      <= 7'd0;
            r_row_base <= c_BASE;
            r_finish   <= 1'b0;
          end
        end
        S_PRIME: begin
          r_cyc <= r_cyc + 2'd1;
          if (r_cyc == 2'd0) begin
            for (int k = 0; k < 3; k++) r_win[k][0] <= 32'd0;
          end
          if (r_cyc == 2'd3) r_state <= S_FETCH;
        end
        S_FETCH: begin
          r_cyc <= r_cyc + 2'd1;
          if (r_cyc == 2'd3) begin
            r_state <= S_EMIT;
            r_valid <= 1'b1;
          end
        end
        S_EMIT: begin
          if (win_ready) begin
            r_valid <= 1'b0;
            for (int k = 0; k < 3; k++) begin
              r_win[k][0] <= r_win[k][1];
              r_win[k][1] <= r_win[k][2];
            end
            if (r_col == c_LAST_COL) begin
              r_col      <= 7'd0;
              r_row      <= r_row + 9'd1;
              r_row_base <= r_row_base + c_W;
              if (r_row == c_LAST_ROW) begin
                r_state  <= S_DONE;
                r_finish <= 1'b1;
              end else begin
                r_state  <= S_PRIME;
              end
            end else begin
              r_col   <= r_col + 7'd1;
              r_state <= S_FETCH;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Byte 6k+j: j=0 is the last pixel of column c-1, j=5 the first of column c+1.
  always_comb begin
    win = '0;
    if (r_valid) begin
      for (int k = 0; k < 3; k++) begin
        win[48*k      +: 8]  = r_win[k][0][31:24];
        win[48*k + 8  +: 32] = r_win[k][1];
        win[48*k + 40 +: 8]  = r_win[k][2][7:0];
      end
    end
  end

  assign win_valid = r_valid;
  assign win_row   = r_valid ? r_row : 9'd0;
  assign win_col   = r_valid ? r_col : 7'd0;
  assign win_first = r_valid && (r_row == 9'd0) && (r_col == 7'd0);
  assign win_last  = r_valid && (r_row == c_LAST_ROW) && (r_col == c_LAST_COL);
  assign finish    = r_finish;

endmodule
`default_nettype wire

// File: tb/tb_sobel_window_fetch.sv
`default_nettype none
// ============================================================================
// Module  : tb_sobel_window_fetch
// Brief   : Randomized bench; windows are predicted from a pixel array model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sobel_window_fetch;

  localparam int W     = 12;
  localparam int H     = 10;
  localparam int SB    = 40;
  localparam int NWIN  = W * H;
  localparam int LIMIT = 60 * NWIN + 1000;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [15:0]  addr;
  logic         en;
  logic         we;
  logic [31:0]  dataR = 32'd0;
  logic         win_valid;
  logic         win_ready;
  logic [143:0] win;
  logic [8:0]   win_row;
  logic [6:0]   win_col;
  logic         win_first;
  logic         win_last;
  logic         finish;

  logic [7:0]   img [H][4*W];
  int           issued[$];
  int           n_checks = 0;
  int           n_fail   = 0;

  sobel_window_fetch #(.IMG_W_WORDS(W), .IMG_H(H), .SRC_BASE(SB)) dut (
    .clk(clk), .reset(reset), .start(start), .addr(addr), .en(en), .we(we),
    .dataR(dataR), .win_valid(win_valid), .win_ready(win_ready), .win(win),
    .win_row(win_row), .win_col(win_col), .win_first(win_first),
    .win_last(win_last), .finish(finish)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [143:0] got, input logic [143:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Word memory: unmapped or idle cycles return garbage so missing zero-fill shows up.
  always @(posedge clk) begin
    if (en && int'(addr) >= SB && int'(addr) < SB + NWIN) begin
      int y, c;
      y = (int'(addr) - SB) / W;
      c = (int'(addr) - SB) % W;
      dataR <= {img[y][4*c+3], img[y][4*c+2], img[y][4*c+1], img[y][4*c]};
    end else begin
      dataR <= $urandom;
    end
  end

  always @(negedge clk) begin
    if (en) begin
      issued.push_back(int'(addr));
      check("addr_in_image", (int'(addr) >= SB && int'(addr) < SB + NWIN), 1'b1);
    end
  end

  function automatic logic [143:0] exp_win(input int r, input int c);
    logic [143:0] v;
    v = '0;
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 6; j++) begin
        int y, x;
        y = r - 1 + k;
        x = 4 * c - 1 + j;
        if (y >= 0 && y < H && x >= 0 && x < 4 * W) v[8*(6*k+j) +: 8] = img[y][x];
      end
    end
    return v;
  endfunction

  function automatic logic [17:0] exp_tag(input int idx);
    return {9'(idx / W), 7'(idx % W), idx == 0, idx == NWIN - 1};
  endfunction

  task automatic fill_img(input bit ramp);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < 4 * W; x++)
        img[y][x] = ramp ? 8'((x + y) % 256) : 8'($urandom_range(0, 255));
  endtask

  task automatic check_first_addrs();
    int exp_a [4];
    exp_a = '{SB, SB + W, SB + 1, SB + W + 1};
    check("issue_count", issued.size() >= 4, 1'b1);
    for (int i = 0; i < 4 && i < issued.size(); i++)
      check($sformatf("first_addr%0d", i), issued[i], exp_a[i]);
  endtask

  // Runs one frame from a start pulse; called at a negedge with the DUT idle/done.
  task automatic run_frame(input int ready_pct, input int stall_idx, input int abort_idx,
                           input bit busy_starts, output int cycles);
    int           idx, guard, stall_cnt, waitc;
    bit           rdy, holding, just_xfer;
    logic [143:0] hold_win;
    logic [17:0]  hold_tag;
    idx = 0; guard = 0; stall_cnt = 0; holding = 0; just_xfer = 0;
    issued.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles = 0;
    while (idx < NWIN && guard < LIMIT) begin
      start = busy_starts && ($urandom_range(0, 29) == 0);
      if (just_xfer) check("valid_drop", win_valid, 1'b0);
      just_xfer = 0;
      if (holding) begin
        check("hold_valid", win_valid, 1'b1);
        check("hold_win", win, hold_win);
        check("hold_tag", {win_row, win_col, win_first, win_last}, hold_tag);
      end
      if (win_valid) begin
        check("en_in_emit", en, 1'b0);
        if (idx == abort_idx) begin
          win_ready = 1'b0;
          start = 1'b0;
          reset = 1'b0;
          @(negedge clk);
          check("abort_valid", win_valid, 1'b0);
          check("abort_en", en, 1'b0);
          check("abort_win", win, 144'd0);
          reset = 1'b1;
          return;
        end
        if (idx == stall_idx) begin
          rdy = (stall_cnt >= 10);
          stall_cnt++;
        end else begin
          rdy = ($urandom_range(1, 100) <= ready_pct);
        end
        win_ready = rdy;
        if (rdy) begin
          check($sformatf("win%0d", idx), win, exp_win(idx / W, idx % W));
          check($sformatf("tag%0d", idx), {win_row, win_col, win_first, win_last}, exp_tag(idx));
          idx++;
          holding = 0;
          just_xfer = 1;
        end else begin
          holding = 1;
          hold_win = win;
          hold_tag = {win_row, win_col, win_first, win_last};
        end
      end else begin
        win_ready = ($urandom_range(1, 100) <= ready_pct);
        holding = 0;
      end
      if (idx < NWIN) begin
        @(negedge clk);
        cycles++;
        guard++;
      end
    end
    check("transfer_count", idx, NWIN);
    @(negedge clk);
    cycles++;
    start = 1'b0;
    waitc = 0;
    while (!finish && waitc < 2) begin
      @(negedge clk);
      cycles++;
      waitc++;
    end
    check("finish_after_last", finish, 1'b1);
    check("valid_after_last", win_valid, 1'b0);
    win_ready = 1'b0;
  endtask

  initial begin
    int cyc;
    reset = 1'b0;
    start = 1'b1;
    win_ready = 1'b0;
    fill_img(1'b1);
    repeat (3) @(negedge clk);
    check("rst_en", en, 1'b0);
    check("rst_we", we, 1'b0);
    check("rst_valid", win_valid, 1'b0);
    check("rst_finish", finish, 1'b0);
    check("rst_addr", addr, 16'd0);
    check("rst_win", {win, win_row, win_col, win_first, win_last}, '0);
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    check("idle_en", en, 1'b0);

    // Ramp image, consumer always ready: checks first window contents and frame length.
    run_frame(100, -1, -1, 1'b0, cyc);
    check_first_addrs();
    check($sformatf("throughput cycles=%0d", cyc),
          (cyc >= H * (5 * W + 4) - 2) && (cyc <= H * (5 * W + 4) + 2), 1'b1);
    repeat (3) @(negedge clk);
    check("done_hold", finish, 1'b1);

    // Random image, random backpressure, a 10-cycle stall at (5,7), stray starts.
    fill_img(1'b0);
    run_frame(60, 5 * W + 7, -1, 1'b1, cyc);
    check_first_addrs();

    // Reset in the middle of a frame, then a clean restart.
    fill_img(1'b0);
    run_frame(70, -1, NWIN / 2 + 3, 1'b0, cyc);
    check("post_reset_finish", finish, 1'b0);
    @(negedge clk);
    fill_img(1'b0);
    run_frame(80, -1, -1, 1'b1, cyc);
    check_first_addrs();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sobel_window_fetch.md
Name: sobel_window_fetch

Overview:
- Upstream feeder for the Sobel datapath in the edge-detection accelerator.
- Reads the source image from the shared word memory, 4 pixels per 32-bit word, 352x288 pixels.
- Produces one 3-row x 6-pixel window per output word, so the consumer can compute 4 Sobel results per beat.
- Out-of-image pixels are zero-filled; windows are delivered over a valid/ready handshake with position tags.

Parameters:
- IMG_W_WORDS, 88, image width in 32-bit words (352 px).
- IMG_H, 288, image height in rows.
- SRC_BASE, 0, word address of pixel (0,0).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; begins a frame when idle or done
- addr  out  16  memory word address
- en  out  1  memory read request
- we  out  1  always 0
- dataR  in  32  read data; valid the cycle after the en/addr cycle; pixel x=4c+i in bits [8i+7:8i]
- win_valid  out  1  window available
- win_ready  in  1  consumer accepts window
- win  out  144  byte (6k+j) = row k (0 = r-1, 1 = r, 2 = r+1), pixel column 4c-1+j (j = 0..5)
- win_row  out  9  output row r
- win_col  out  7  output word column c
- win_first  out  1  r=0 and c=0
- win_last  out  1  r=IMG_H-1 and c=IMG_W_WORDS-1
- finish  out  1  frame complete

Behaviour:
- Reset: reset=0 at a clock edge sets state IDLE. All outputs go to 0, including addr, win, the tags and finish. This applies mid-frame too: in-flight reads are discarded and no window is emitted.
- Word address: word (row,col) = SRC_BASE + row*IMG_W_WORDS + col. Computed with running counters; no multiplier.
- Storage: a 3x3 word register holds columns c-1, c and c+1 for rows r-1, r and r+1.
- IDLE:
  - start=1 -> PRIME with r=0, c=0, finish=0.
  - start is ignored in all states except IDLE and DONE.
- PRIME (4 cycles):
  - Column c-1 words are loaded as zero.
  - Fetch column 0 into the c slots.
  - Then -> FETCH.
- FETCH (4 cycles):
  - Cycle 0: read top word (row r-1, col c+1). Cycle 1: middle (row r). Cycle 2: bottom (row r+1). Cycle 3: no issue.
  - Each word is captured at the end of the cycle after its issue.
  - A word whose row is <0 or >=IMG_H, or whose col is >=IMG_W_WORDS, is not read: en=0 that cycle and zero is captured. Cycle count is unchanged.
  - Then -> EMIT.
- EMIT:
  - win_valid=1; win is built from the 3x3 registers.
  - Byte j=0 comes from byte 3 of column c-1. Bytes j=1..4 come from column c. Byte j=5 comes from byte 0 of column c+1.
  - win, win_row, win_col, win_first and win_last stay stable while win_valid=1 and win_ready=0. en=0 during EMIT.
  - Transfer occurs on win_valid && win_ready. win_valid drops the next cycle.
  - After transfer, shift columns left (c -> c-1, c+1 -> c) and increment c.
  - If c was IMG_W_WORDS-1: c=0, r++. Then -> PRIME if r<IMG_H, else -> DONE.
  - Otherwise -> FETCH.
- DONE:
  - finish=1, held until start.
  - start in DONE restarts the frame: finish=0, -> PRIME.
- Throughput with win_ready held 1:
  - 5 cycles per window plus 4 per row.
  - 444 cycles per row; 127872 cycles from start sample to DONE (±2).
- Counter widths: r is 9 bits, c is 7 bits. No wrap occurs within a frame.
- If start and reset=0 coincide, reset wins.

Test Plan:
- Reset: hold reset=0 for 3 cycles with start=1 -> en=0, we=0, win_valid=0, finish=0, addr=0.
- First window:
  - Stimulus: pixel(x,y)=(x+y) mod 256; pulse start.
  - en/addr sequence is 0, 88 (PRIME), then 1, 89 (FETCH).
  - First window: win_row=0, win_col=0, win_first=1.
  - Row k=0: all zero. Row k=1: 00,00,01,02,03,04. Row k=2: 00,01,02,03,04,05.
- Backpressure: win_ready=0 for 10 cycles at window (5,10) -> win_valid stays 1, win and tags are bit-stable, en=0 throughout; accepted on the first ready cycle.
- Last window: window (287,87) -> win_last=1, row k=2 all zero, byte j=5 of every row zero. finish=1 within 2 cycles after transfer. Exactly 25344 transfers are counted.
- Throughput: win_ready tied 1 -> finish rises 127872±2 cycles after start.
- Reset and restart:
  - Assert reset=0 while window 1000 is pending -> next edge win_valid=0, en=0.
  - Release and pulse start -> addr sequence restarts at 0, and the first window is (0,0).
  - A start pulse while busy (mid-frame) causes no change to the addr sequence.
